// File: rtl/btb_port_scheduler_if.sv
// rtl/btb_port_scheduler_if.sv - request/RAM bundle between fetch/feedback logic and the BTB port scheduler
//
// Purpose: groups the branch-feedback update requests, fetch lookup requests,
// the two BTB RAM port drives and the lookup response flags.
// master: fetch/feedback side (drives fb_* and rd_* requests)
// slave : btb_port_scheduler (drives grants, RAM ports, responses, q_count)
//   fb_valid/fb_branch_pc/fb_new_pc  update requests, fb_ready accept flag
//   rd_valid/rd_addr                 lookup requests, rd_grant issue flag
//   ram_addr/ram_we/ram_din          per-port RAM controls
//   resp_valid/resp_port             dout valid and carrying port per lookup
//   q_count                          pending updates
interface btb_port_scheduler_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 10,
  parameter int LINE_WIDTH = 2*ADDR_WIDTH-IDX_WIDTH-2,
  parameter int QDEPTH     = 4
);
  logic [1:0]                 fb_valid;
  logic [1:0][ADDR_WIDTH-1:0] fb_branch_pc;
  logic [1:0][ADDR_WIDTH-1:0] fb_new_pc;
  logic                       fb_ready;
  logic [1:0]                 rd_valid;
  logic [1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]                 rd_grant;
  logic [1:0][IDX_WIDTH-1:0]  ram_addr;
  logic [1:0]                 ram_we;
  logic [1:0][LINE_WIDTH-1:0] ram_din;
  logic [1:0]                 resp_valid;
  logic [1:0]                 resp_port;
  logic [$clog2(QDEPTH):0]    q_count;

  modport master (
    output fb_valid, fb_branch_pc, fb_new_pc, rd_valid, rd_addr,
    input  fb_ready, rd_grant, ram_addr, ram_we, ram_din, resp_valid, resp_port, q_count
  );

  modport slave (
    input  fb_valid, fb_branch_pc, fb_new_pc, rd_valid, rd_addr,
    output fb_ready, rd_grant, ram_addr, ram_we, ram_din, resp_valid, resp_port, q_count
  );
endinterface

// File: rtl/btb_port_scheduler.sv
// rtl/btb_port_scheduler.sv - shares the two BTB RAM ports between fetch lookups and buffered branch updates
//
// Purpose: branch-resolution updates are buffered in a small circular FIFO
// and drained into RAM ports that fetch lookups leave idle. Lookups have
// priority; after STARVE_LIMIT cycles of pending updates with no drain,
// port0 is forced to write the FIFO head.
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    btb_port_scheduler_if slave modport (requests, grants, RAM ports,
//          responses, q_count)
module btb_port_scheduler #(
  parameter int ADDR_WIDTH   = 32,
  parameter int IDX_WIDTH    = 10,
  parameter int LINE_WIDTH   = 2*ADDR_WIDTH-IDX_WIDTH-2,
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  btb_port_scheduler_if.slave  bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [IDX_WIDTH-1:0]  q_idx  [QDEPTH];
  logic [LINE_WIDTH-1:0] q_line [QDEPTH];
  logic [PW-1:0]         head, tail, head_nx, tail_nx, slot1;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve;
  logic [1:0]            resp_valid_q, resp_port_q;

  logic                  ready, nonempty, force_mode;
  logic [1:0]            enq_n, deq_n;
  logic [1:0][IDX_WIDTH-1:0] rd_idx;

  logic                  wr0, wr1, rd_on0, rd_on1, src0, src1;
  logic [1:0]            we, grant, rport;
  logic [1:0][IDX_WIDTH-1:0]  addr;
  logic [1:0][LINE_WIDTH-1:0] din;

  logic unused_bits;
  assign unused_bits = ^{bus.fb_branch_pc[0][1:0], bus.fb_branch_pc[1][1:0],
                         bus.rd_addr[0][1:0], bus.rd_addr[1][1:0],
                         bus.rd_addr[0][ADDR_WIDTH-1:IDX_WIDTH+2],
                         bus.rd_addr[1][ADDR_WIDTH-1:IDX_WIDTH+2]};

  assign head_nx    = head + PW'(1);
  assign tail_nx    = tail + PW'(1);
  assign nonempty   = (count != '0);
  assign force_mode = nonempty && (starve == SW'(STARVE_LIMIT));
  // Acceptance is always for two slots so a dual update never splits.
  assign ready      = (CW'(QDEPTH) - count) >= CW'(2);
  assign enq_n      = ready ? ({1'b0, bus.fb_valid[0]} + {1'b0, bus.fb_valid[1]}) : 2'd0;
  assign deq_n      = {1'b0, we[0]} + {1'b0, we[1]};
  assign slot1      = bus.fb_valid[0] ? tail_nx : tail;
  assign rd_idx[0]  = bus.rd_addr[0][IDX_WIDTH+1:2];
  assign rd_idx[1]  = bus.rd_addr[1][IDX_WIDTH+1:2];

  // Port plan: which port writes which FIFO entry and which read each port carries.
  always_comb begin
    wr0 = 1'b0; wr1 = 1'b0;
    rd_on0 = 1'b0; rd_on1 = 1'b0;
    src0 = 1'b0; src1 = 1'b0;
    if (force_mode) begin
      wr0    = 1'b1;
      rd_on1 = |bus.rd_valid;
      src1   = ~bus.rd_valid[0];
    end else if (&bus.rd_valid) begin
      rd_on0 = 1'b1; src0 = 1'b0;
      rd_on1 = 1'b1; src1 = 1'b1;
    end else if (|bus.rd_valid) begin
      if (nonempty) begin
        wr0    = 1'b1;
        rd_on1 = 1'b1;
        src1   = bus.rd_valid[1];
      end else if (bus.rd_valid[0]) begin
        rd_on0 = 1'b1; src0 = 1'b0;
      end else begin
        rd_on1 = 1'b1; src1 = 1'b1;
      end
    end else if (nonempty) begin
      wr0 = 1'b1;
      // Two writes to one index in the same cycle would race in the RAM.
      wr1 = (count >= CW'(2)) && (q_idx[head] != q_idx[head_nx]);
    end
  end

  // Port drive; a read that hits the index of a same-cycle write is dropped.
  always_comb begin
    we = '0; addr = '0; din = '0; grant = '0; rport = '0;
    if (wr0) begin
      we[0]   = 1'b1;
      addr[0] = q_idx[head];
      din[0]  = q_line[head];
    end else if (rd_on0 && !(wr1 && rd_idx[src0] == q_idx[head_nx])) begin
      addr[0]     = rd_idx[src0];
      grant[src0] = 1'b1;
      rport[src0] = 1'b0;
    end
    if (wr1) begin
      we[1]   = 1'b1;
      addr[1] = q_idx[head_nx];
      din[1]  = q_line[head_nx];
    end else if (rd_on1 && !(wr0 && rd_idx[src1] == q_idx[head])) begin
      addr[1]     = rd_idx[src1];
      grant[src1] = 1'b1;
      rport[src1] = 1'b1;
    end
    if (!reset) begin
      we = '0; addr = '0; din = '0; grant = '0; rport = '0;
    end
  end

  // FIFO storage needs no reset; validity lives in head/tail/count.
  always_ff @(posedge clk) begin
    if (ready && bus.fb_valid[0]) begin
      q_idx[tail]  <= bus.fb_branch_pc[0][IDX_WIDTH+1:2];
      q_line[tail] <= {bus.fb_branch_pc[0][ADDR_WIDTH-1:IDX_WIDTH+2], bus.fb_new_pc[0]};
    end
    if (ready && bus.fb_valid[1]) begin
      q_idx[slot1]  <= bus.fb_branch_pc[1][IDX_WIDTH+1:2];
      q_line[slot1] <= {bus.fb_branch_pc[1][ADDR_WIDTH-1:IDX_WIDTH+2], bus.fb_new_pc[1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      starve       <= '0;
      resp_valid_q <= '0;
      resp_port_q  <= '0;
    end else begin
      head  <= head + PW'(deq_n);
      tail  <= tail + PW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
      if (!nonempty || deq_n != 2'd0) begin
        starve <= '0;
      end else if (starve != SW'(STARVE_LIMIT)) begin
        starve <= starve + SW'(1);
      end
      resp_valid_q <= grant;
      resp_port_q  <= rport & grant;
    end
  end

  assign bus.fb_ready   = ready;
  assign bus.rd_grant   = grant;
  assign bus.ram_we     = we;
  assign bus.ram_addr   = addr;
  assign bus.ram_din    = din;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_port  = resp_port_q;
  assign bus.q_count    = count;
endmodule

// File: tb/tb_btb_port_scheduler.sv
// tb/tb_btb_port_scheduler.sv - randomized and directed checks of btb_port_scheduler against a queue model
module tb_btb_port_scheduler;
  localparam int AW = 32;
  localparam int IW = 10;
  localparam int LW = 2*AW-IW-2;
  localparam int QD = 4;
  localparam int SL = 8;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [LW-1:0] line;
  } upd_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  btb_port_scheduler_if #(.ADDR_WIDTH(AW), .IDX_WIDTH(IW), .LINE_WIDTH(LW), .QDEPTH(QD)) bus ();

  btb_port_scheduler #(
    .ADDR_WIDTH(AW), .IDX_WIDTH(IW), .LINE_WIDTH(LW), .QDEPTH(QD), .STARVE_LIMIT(SL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  upd_t mq[$];
  int   starve_m;
  logic [1:0] m_rv, m_rp;
  logic [1:0] e_we, e_grant, e_port;
  logic [1:0][IW-1:0] e_addr;
  logic [1:0][LW-1:0] e_din;
  int   e_nw;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_pc();
    logic [AW-1:0] a = $urandom();
    a[IW+1:2] = IW'($urandom_range(0, 3));
    return a;
  endfunction

  task automatic idle();
    bus.fb_valid = '0; bus.fb_branch_pc = '0; bus.fb_new_pc = '0;
    bus.rd_valid = '0; bus.rd_addr = '0;
  endtask

  task automatic model_clear();
    mq.delete(); starve_m = 0; m_rv = '0; m_rp = '0;
  endtask

  // Expected port usage for this cycle, straight from the allocation rules.
  task automatic predict();
    int n;
    bit frc;
    int rp[2];
    logic [IW-1:0] ridx;
    bit coll;
    n = mq.size();
    frc = (starve_m >= SL) && (n > 0);
    e_we = '0; e_grant = '0; e_port = '0; e_addr = '0; e_din = '0; e_nw = 0;
    rp[0] = -1; rp[1] = -1;
    if (frc) begin
      e_nw = 1;
      if (bus.rd_valid[0]) rp[0] = 1;
      else if (bus.rd_valid[1]) rp[1] = 1;
    end else if (bus.rd_valid == 2'b11) begin
      rp[0] = 0; rp[1] = 1;
    end else if (bus.rd_valid != 2'b00) begin
      int k;
      k = bus.rd_valid[1] ? 1 : 0;
      if (n > 0) begin e_nw = 1; rp[k] = 1; end
      else rp[k] = k;
    end else if (n > 0) begin
      e_nw = (n >= 2 && mq[0].idx != mq[1].idx) ? 2 : 1;
    end
    for (int w = 0; w < e_nw; w++) begin
      e_we[w] = 1'b1; e_addr[w] = mq[w].idx; e_din[w] = mq[w].line;
    end
    for (int k = 0; k < 2; k++) begin
      if (rp[k] >= 0) begin
        ridx = bus.rd_addr[k][IW+1:2];
        coll = 0;
        for (int w = 0; w < e_nw; w++) if (mq[w].idx == ridx) coll = 1;
        if (!coll) begin
          e_grant[k] = 1'b1;
          e_addr[rp[k]] = ridx;
          e_port[k] = (rp[k] == 1);
        end
      end
    end
  endtask

  task automatic update_model();
    int n;
    bit rdy;
    upd_t u;
    n = mq.size();
    rdy = (QD - n) >= 2;
    repeat (e_nw) void'(mq.pop_front());
    if (n == 0 || e_nw > 0) starve_m = 0;
    else if (starve_m < SL) starve_m = starve_m + 1;
    if (rdy) begin
      for (int k = 0; k < 2; k++) begin
        if (bus.fb_valid[k]) begin
          u.idx  = bus.fb_branch_pc[k][IW+1:2];
          u.line = {bus.fb_branch_pc[k][AW-1:IW+2], bus.fb_new_pc[k]};
          mq.push_back(u);
        end
      end
    end
    m_rv = e_grant;
    m_rp = e_port;
  endtask

  task automatic compare_all();
    check("fb_ready",   bus.fb_ready, (QD - mq.size()) >= 2);
    check("q_count",    bus.q_count, mq.size());
    check("resp_valid", bus.resp_valid, m_rv);
    check("resp_port",  bus.resp_port, m_rp);
    check("rd_grant",   bus.rd_grant, e_grant);
    check("ram_we",     bus.ram_we, e_we);
    check("ram_addr",   bus.ram_addr, e_addr);
    check("ram_din",    bus.ram_din, e_din);
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic tick();
    @(negedge clk);
    predict();
    compare_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_q_count"},    bus.q_count, 0);
    check({tag, "_ram_we"},     bus.ram_we, 2'b00);
    check({tag, "_resp_valid"}, bus.resp_valid, 2'b00);
    check({tag, "_rd_grant"},   bus.rd_grant, 2'b00);
    check({tag, "_ram_addr"},   bus.ram_addr, 0);
    check({tag, "_ram_din"},    bus.ram_din, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 reset_checks("rst_async");
    @(posedge clk);
    #1 reset_checks("rst_held");
    idle();
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] line_exp;
    reset = 1'b0;
    idle();
    model_clear();
    bus.rd_valid = 2'b11;
    bus.rd_addr[0] = 32'h40; bus.rd_addr[1] = 32'h80;
    #12 reset_checks("por");
    @(posedge clk);
    #1 idle();
    reset = 1'b1;

    // single update drains on port0 the next cycle
    bus.fb_valid = 2'b01; bus.fb_branch_pc[0] = 32'h1000; bus.fb_new_pc[0] = 32'h2000;
    tick();
    idle();
    line_exp = {20'h00001, 32'h0000_2000};
    check("t1_we", bus.ram_we, 2'b01);
    check("t1_addr0", bus.ram_addr[0], 10'h000);
    check("t1_din0", bus.ram_din[0], line_exp);
    tick();
    check("t1_q_empty", bus.q_count, 0);

    // both reads every cycle: starvation forces the write on cycle 9
    bus.rd_valid = 2'b11; bus.rd_addr[0] = 32'h40; bus.rd_addr[1] = 32'h80;
    bus.fb_valid = 2'b01; bus.fb_branch_pc[0] = 32'h3000; bus.fb_new_pc[0] = 32'h4444;
    tick();
    bus.fb_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      check("t2_no_drain", bus.ram_we, 2'b00);
      tick();
    end
    check("t2_force_we", bus.ram_we, 2'b01);
    check("t2_force_grant", bus.rd_grant, 2'b01);
    check("t2_force_addr1", bus.ram_addr[1], 10'h010);
    tick();
    check("t2_resp_valid", bus.resp_valid, 2'b01);
    check("t2_resp_port", bus.resp_port, 2'b01);

    // fill 2+2 while reads block draining; held request is ignored
    bus.fb_valid = 2'b11;
    bus.fb_branch_pc[0] = rand_pc(); bus.fb_branch_pc[1] = rand_pc();
    bus.fb_new_pc[0] = $urandom(); bus.fb_new_pc[1] = $urandom();
    tick();
    tick();
    check("t3_ready_full", bus.fb_ready, 1'b0);
    check("t3_count_full", bus.q_count, 4);
    tick();
    check("t3_count_held", bus.q_count, 4);
    idle();
    for (int i = 0; i < 6; i++) tick();

    // single read colliding with the head write is denied
    bus.fb_valid = 2'b01; bus.fb_branch_pc[0] = 32'h1000; bus.fb_new_pc[0] = 32'h2000;
    bus.rd_valid = 2'b10; bus.rd_addr[1] = 32'h1000;
    tick();
    bus.fb_valid = 2'b00;
    check("t4_coll_grant", bus.rd_grant, 2'b00);
    check("t4_coll_we", bus.ram_we, 2'b01);
    check("t4_coll_addr1", bus.ram_addr[1], 10'h000);
    tick();
    bus.fb_valid = 2'b01; bus.rd_addr[1] = 32'h1004;
    tick();
    bus.fb_valid = 2'b00;
    check("t4_ok_grant", bus.rd_grant, 2'b10);
    check("t4_ok_addr1", bus.ram_addr[1], 10'h001);
    check("t4_ok_we", bus.ram_we, 2'b01);
    tick();
    idle();

    // equal-index pair drains one per cycle; distinct pair drains together
    bus.fb_valid = 2'b11;
    bus.fb_branch_pc[0] = 32'h1000; bus.fb_branch_pc[1] = 32'h5000;
    bus.fb_new_pc[0] = 32'h11; bus.fb_new_pc[1] = 32'h22;
    tick();
    idle();
    check("t5_eq_first", bus.ram_we, 2'b01);
    tick();
    check("t5_eq_second", bus.ram_we, 2'b01);
    tick();
    check("t5_eq_done", bus.ram_we, 2'b00);
    bus.fb_valid = 2'b11;
    bus.fb_branch_pc[0] = 32'h1000; bus.fb_branch_pc[1] = 32'h1008;
    tick();
    idle();
    check("t5_ne_both", bus.ram_we, 2'b11);
    check("t5_ne_addr1", bus.ram_addr[1], 10'h002);
    tick();

    // reset with three updates pending
    bus.rd_valid = 2'b11; bus.rd_addr[0] = 32'h40; bus.rd_addr[1] = 32'h80;
    bus.fb_valid = 2'b11; bus.fb_branch_pc[0] = rand_pc(); bus.fb_branch_pc[1] = rand_pc();
    tick();
    bus.fb_valid = 2'b01;
    tick();
    bus.fb_valid = 2'b00; bus.rd_valid = 2'b00;
    check("t6_count3", bus.q_count, 3);
    do_reset();
    check("t6_ready_after", bus.fb_ready, 1'b1);
    check("t6_no_write", bus.ram_we, 2'b00);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      bus.rd_valid = 2'($urandom());
      bus.rd_addr[0] = rand_pc(); bus.rd_addr[1] = rand_pc();
      bus.fb_valid = 2'($urandom());
      bus.fb_branch_pc[0] = rand_pc(); bus.fb_branch_pc[1] = rand_pc();
      bus.fb_new_pc[0] = $urandom(); bus.fb_new_pc[1] = $urandom();
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/btb_port_scheduler.md
Name: btb_port_scheduler

Overview:
- Sequences the two shared BRAM ports of the branch target buffer between fetch lookups (2 read requesters) and branch-resolution updates (2 write requesters).
- Replaces the "stall when more than 2 port requests" policy: feedback updates are buffered in a small FIFO and drained into idle ports. Reads have priority, and a starvation guard forces writes through.
- Sits between fetch/branch-feedback logic and the BTB RAM. Drives the RAM address/we/din directly and tells fetch which lookups were granted and when their data is valid.

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- IDX_WIDTH, 10, BTB index width (log2 of entries).
- LINE_WIDTH, 2*ADDR_WIDTH-IDX_WIDTH-2, RAM line width: tag + target.
- QDEPTH, 4, update FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 8, consecutive cycles with pending updates and zero drains before write-forcing.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- fb_valid[2]  in  1  branch feedback update request
- fb_branch_pc[2]  in  ADDR_WIDTH  PC of resolved branch
- fb_new_pc[2]  in  ADDR_WIDTH  resolved target
- fb_ready  out  1  FIFO has >=2 free slots; updates accepted this cycle
- rd_valid[2]  in  1  fetch lookup request
- rd_addr[2]  in  ADDR_WIDTH  fetch PC
- rd_grant[2]  out  1  lookup k issued to a RAM port this cycle
- ram_addr[2]  out  IDX_WIDTH  RAM port address
- ram_we[2]  out  1  RAM port write enable
- ram_din[2]  out  LINE_WIDTH  RAM write data
- resp_valid[2]  out  1  RAM dout for lookup k valid this cycle
- resp_port[2]  out  1  RAM port carrying lookup k's dout
- q_count  out  $clog2(QDEPTH)+1  pending updates

Behaviour:
- Index = pc[IDX_WIDTH+1:2]. Write line = {branch_pc[ADDR_WIDTH-1:IDX_WIDTH+2], new_pc}.
- Enqueue at the clock edge when fb_ready=1. fb[0] is enqueued before fb[1]; a single valid request takes one slot. fb_valid with fb_ready=0 is ignored, and the requester holds.
- Circular FIFO with head/tail pointers that wrap modulo QDEPTH. An entry is drainable no earlier than the cycle after enqueue (no bypass).
- Port allocation (combinational on current state and rd inputs):
  - Both reads valid, normal mode: port0=rd0, port1=rd1, no drain.
  - One read k valid and queue non-empty: port0 writes the head, port1 reads rd k.
  - One read k valid and queue empty: port k reads rd k, the other port is idle.
  - No reads: port0 writes the head. Port1 writes head+1 if q_count>=2 and its index differs from the head's. On an index match only the head drains.
  - Idle ports: we=0, addr=0, din=0.
- Index collision: if a read's index equals the index of a write issued in the same cycle, that read gets rd_grant=0 and its port stays idle. The write is unaffected.
- Starvation counter:
  - Increments each cycle with q_count>0 and zero drains.
  - Clears on any drain or when the queue is empty.
  - Saturates at STARVE_LIMIT.
  - At STARVE_LIMIT (force mode): port0 writes the head and port1 reads rd0 if valid, else rd1. The other read is denied.
- Dequeue happens at the edge for every write issued. Enqueue and dequeue in the same cycle are both applied, and q_count updates by the net difference.
- Responses: resp_valid[k] is rd_grant[k] registered one cycle, and resp_port[k] records the port used. Both clear the cycle after the grant drops.
- Reset (reset=0, async):
  - State: FIFO empty, q_count=0, starve counter=0, resp_valid=0, resp_port=0.
  - Outputs while reset is asserted: rd_grant=0, ram_we=0, ram_addr=0, ram_din=0.
  - Outputs after reset release: fb_ready=1.
  - Reset mid-operation discards queued updates.
- fb_ready = (QDEPTH - q_count) >= 2, from registered count. The queue never overflows.

Test Plan:
- After reset, fb_valid[0]=1 with branch_pc=0x1000, new_pc=0x2000 and no reads -> next cycle ram_we[0]=1, ram_addr[0]=0x000 (pc[11:2] of 0x1000 with IDX_WIDTH=10), ram_din[0]={tag 0x1, 0x2000}. The following cycle q_count=0.
- Both reads valid every cycle, 1 update queued -> no drain for 8 cycles. Cycle 9: port0 writes, rd_grant=2'b01, port1 reads rd0. Next cycle resp_valid=2'b01 and resp_port[0]=1.
- Fill FIFO with 2+2 updates while reads block draining -> fb_ready=0 at q_count=3 and 4. fb_valid held while fb_ready=0 is not enqueued and q_count stays 4.
- rd_valid[1] only, rd_addr=0x1000, head update index 0x000 -> rd_grant[1]=0, ram_we[0]=1, port1 idle. With rd_addr=0x1004 instead -> rd_grant[1]=1 and port1 reads idx 0x001.
- Two queued updates with equal index and no reads -> one write per cycle over two cycles. With distinct indices -> both written in one cycle.
- Assert reset mid-drain with q_count=3 -> q_count=0, ram_we=0 and resp_valid=0 while reset is low. After release fb_ready=1 and no write occurs.
